// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared constants and state encodings for the uart tx arbiter
package uart_tx_arbiter_pkg;
    localparam int NUM_DATA_BITS = 8;
    localparam int BYTE_PERIOD = NUM_DATA_BITS + 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_WAIT_DONE} arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: first asserted request at or after ptr, searching upward modulo NUM_REQ
module rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               found
);
    logic [IW-1:0] idx;
    // descending scan so the candidate closest to ptr is the one left standing
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            winner = req[idx] ? idx : winner;
            found = found | req[idx];
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one uart_tx between requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_BITS = NUM_DATA_BITS,
    parameter int ACCEPT_TIMEOUT = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                         baud,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [IW-1:0]                grant_id,
    output logic                         arb_busy,
    output logic [15:0]                  bytes_sent,
    output logic                         err_timeout,
    output logic                         err_uart,
    output logic                         uart_enable,
    output logic                         uart_write,
    output logic [DATA_BITS-1:0]         uart_data,
    input  logic                         uart_done,
    input  logic                         uart_busy,
    input  logic                         uart_error
);
    localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);
    arb_state_t state, state_nxt;
    logic [IW-1:0] rr, winner, nxt_id;
    logic [CW-1:0] cnt;
    logic [NUM_REQ-1:0] cand;
    logic lock, last_flag, found, issue, timed_out, done_hit;
    // while a message is locked only its owner may be picked
    assign cand = lock ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
    assign nxt_id = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (cand),
        .ptr    (rr),
        .winner (winner),
        .found  (found)
    );
    // next-state and handshake events
    always_comb begin
        issue = (state == ST_IDLE) && found && uart_enable && !uart_busy;
        timed_out = (state == ST_ACCEPT) && !uart_busy && (cnt == CW'(ACCEPT_TIMEOUT - 1));
        done_hit = (state == ST_WAIT_DONE) && uart_done;
        state_nxt = issue ? ST_ACCEPT :
                    (state == ST_ACCEPT && uart_busy) ? ST_WAIT_DONE :
                    (timed_out || done_hit) ? ST_IDLE : state;
    end
    // state register
    always_ff @(posedge baud) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end
    // datapath, lock/pointer bookkeeping and status outputs
    always_ff @(posedge baud) begin
        if (!rst_n) begin
            rr <= '0;
            lock <= 1'b0;
            last_flag <= 1'b0;
            cnt <= '0;
            req_ready <= '0;
            grant_id <= '0;
            arb_busy <= 1'b0;
            bytes_sent <= '0;
            err_timeout <= 1'b0;
            err_uart <= 1'b0;
            uart_enable <= 1'b0;
            uart_write <= 1'b0;
            uart_data <= '0;
        end else begin
            uart_enable <= 1'b1;
            uart_write <= issue;
            req_ready <= issue ? (NUM_REQ'(1) << winner) : '0;
            err_uart <= err_uart | uart_error;
            cnt <= (state == ST_ACCEPT) ? cnt + 1'b1 : '0;
            if (issue) begin
                uart_data <= req_data[winner*DATA_BITS +: DATA_BITS];
                grant_id <= winner;
                lock <= ~req_last[winner];
                last_flag <= req_last[winner];
                arb_busy <= 1'b1;
            end
            if (timed_out) begin
                err_timeout <= 1'b1;
                lock <= 1'b0;
                rr <= nxt_id;
                arb_busy <= 1'b0;
            end
            if (done_hit) begin
                bytes_sent <= bytes_sent + 16'd1;
                if (last_flag) begin
                    lock <= 1'b0;
                    rr <= nxt_id;
                    arb_busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table for handshake corners plus randomized message traffic
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DB = 8;
    logic baud = 1'b0;
    logic rst_n;
    logic [NR-1:0] req_valid, req_last, req_ready;
    logic [NR*DB-1:0] req_data;
    logic [1:0] grant_id;
    logic arb_busy, err_timeout, err_uart, uart_enable, uart_write;
    logic [15:0] bytes_sent;
    logic [DB-1:0] uart_data;
    logic uart_done, uart_busy, uart_error;
    int n_tests = 0;
    int n_fail = 0;
    always #5 baud = ~baud;
    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .ACCEPT_TIMEOUT(4)) dut (
        .baud(baud), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id), .arb_busy(arb_busy),
        .bytes_sent(bytes_sent), .err_timeout(err_timeout), .err_uart(err_uart),
        .uart_enable(uart_enable), .uart_write(uart_write), .uart_data(uart_data),
        .uart_done(uart_done), .uart_busy(uart_busy), .uart_error(uart_error)
    );
    typedef struct {
        logic rst_n; logic [3:0] v; logic [3:0] l; logic b; logic d; logic e;
        logic en; logic [3:0] rdy; logic w; logic [7:0] dat; logic [1:0] g;
        logic ab; logic et; logic eu; logic [15:0] by;
    } vec_t;
    vec_t tbl[26];
    bit model_on = 0;
    bit busy_m, pend_w;
    int k_m;
    int hd[NR], len[NR];
    logic [7:0] bd[NR][16];
    logic bl[NR][16];
    logic [9:0] expq[$];
    int p_m;
    logic [15:0] exp_bytes;
    function automatic vec_t mk(input logic r, input logic [3:0] v, l, input logic b, d, e,
                                input logic en, input logic [3:0] rdy, input logic w,
                                input logic [7:0] dat, input logic [1:0] g,
                                input logic ab, et, eu, input logic [15:0] by);
        vec_t t;
        t.rst_n = r; t.v = v; t.l = l; t.b = b; t.d = d; t.e = e;
        t.en = en; t.rdy = rdy; t.w = w; t.dat = dat; t.g = g;
        t.ab = ab; t.et = et; t.eu = eu; t.by = by;
        return t;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive_req();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = hd[i] < len[i];
            req_last[i] = req_valid[i] ? bl[i][hd[i]] : 1'b0;
            req_data[i*DB +: DB] = req_valid[i] ? bd[i][hd[i]] : 8'h00;
        end
    endtask
    task automatic step();
        @(posedge baud);
        #1;
        if (model_on) begin
            uart_done = 1'b0;
            if (busy_m) begin
                k_m++;
                if (k_m == DB + 1) begin
                    busy_m = 0;
                    uart_done = 1'b1;
                end
            end else if (pend_w) begin
                busy_m = 1;
                k_m = 0;
            end
            uart_busy = busy_m;
            pend_w = uart_write;
            for (int i = 0; i < NR; i++) if (req_ready[i]) hd[i]++;
            drive_req();
        end
    endtask
    task automatic build_exp();
        int mh[NR];
        int w;
        logic lst;
        for (int i = 0; i < NR; i++) mh[i] = hd[i];
        forever begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                int j = (p_m + k) % NR;
                if (w < 0 && mh[j] < len[j]) w = j;
            end
            if (w < 0) break;
            do begin
                expq.push_back({2'(w), bd[w][mh[w]]});
                lst = bl[w][mh[w]];
                mh[w]++;
            end while (!lst);
            p_m = (w + 1) % NR;
        end
    endtask
    task automatic gen_round();
        int nm, ln;
        for (int i = 0; i < NR; i++) begin
            hd[i] = 0;
            len[i] = 0;
            nm = $urandom_range(0, 3);
            for (int m = 0; m < nm; m++) begin
                ln = $urandom_range(1, 3);
                for (int b = 0; b < ln; b++) begin
                    bd[i][len[i]] = 8'($urandom);
                    bl[i][len[i]] = (b == ln - 1);
                    len[i]++;
                end
            end
        end
    endtask
    task automatic run_round();
        int cyc = 0;
        int budget;
        logic [9:0] e;
        build_exp();
        exp_bytes = exp_bytes + 16'(expq.size());
        budget = 40 * expq.size() + 50;
        drive_req();
        while ((expq.size() > 0 || arb_busy) && cyc < budget) begin
            step();
            cyc++;
            if (uart_write) begin
                if (expq.size() == 0) chk("rnd_extra_write", {24'h0, uart_data}, 32'hFFFF_FFFF);
                else begin
                    e = expq.pop_front();
                    chk("rnd_data", uart_data, e[7:0]);
                    chk("rnd_grant", grant_id, e[9:8]);
                    chk("rnd_ready", req_ready, 4'b1 << e[9:8]);
                end
            end
        end
        chk("rnd_round_timeout", cyc >= budget, 0);
        chk("rnd_bytes_sent", bytes_sent, exp_bytes);
        chk("rnd_arb_busy", arb_busy, 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        rst_n = 0; req_valid = '0; req_last = '0; req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        uart_done = 0; uart_busy = 0; uart_error = 0;
        tbl[0]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 4'h2, 4'h2, 0, 0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 4'h2, 4'h2, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 4'h2, 4'h2, 0, 0, 0, 1, 4'h2, 1, 8'h22, 1, 1, 0, 0, 0);
        tbl[4]  = mk(1, 4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h22, 1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 8'h22, 1, 1, 0, 0, 0);
        tbl[6]  = mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 8'h22, 1, 1, 0, 0, 0);
        tbl[7]  = mk(1, 4'h0, 4'h0, 0, 1, 0, 1, 4'h0, 0, 8'h22, 1, 0, 0, 0, 1);
        tbl[8]  = mk(1, 4'h2, 4'h2, 0, 0, 0, 1, 4'h2, 1, 8'h22, 1, 1, 0, 0, 1);
        tbl[9]  = mk(1, 4'h4, 4'h4, 0, 0, 0, 1, 4'h0, 0, 8'h22, 1, 1, 0, 0, 1);
        tbl[10] = mk(1, 4'h4, 4'h4, 0, 0, 0, 1, 4'h0, 0, 8'h22, 1, 1, 0, 0, 1);
        tbl[11] = mk(1, 4'h4, 4'h4, 0, 0, 0, 1, 4'h0, 0, 8'h22, 1, 1, 0, 0, 1);
        tbl[12] = mk(1, 4'h4, 4'h4, 0, 0, 0, 1, 4'h0, 0, 8'h22, 1, 0, 1, 0, 1);
        tbl[13] = mk(1, 4'h6, 4'h6, 0, 0, 0, 1, 4'h4, 1, 8'h33, 2, 1, 1, 0, 1);
        tbl[14] = mk(1, 4'h0, 4'h0, 0, 0, 1, 1, 4'h0, 0, 8'h33, 2, 1, 1, 1, 1);
        tbl[15] = mk(1, 4'h0, 4'h0, 0, 1, 0, 1, 4'h0, 0, 8'h33, 2, 1, 1, 1, 1);
        tbl[16] = mk(1, 4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h33, 2, 1, 1, 1, 1);
        tbl[17] = mk(1, 4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h33, 2, 0, 1, 1, 1);
        tbl[18] = mk(1, 4'h1, 4'h0, 0, 0, 0, 1, 4'h1, 1, 8'h11, 0, 1, 1, 1, 1);
        tbl[19] = mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 8'h11, 0, 1, 1, 1, 1);
        tbl[20] = mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 8'h11, 0, 1, 1, 1, 1);
        tbl[21] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[22] = mk(1, 4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 4'h1, 4'h1, 0, 0, 0, 1, 4'h1, 1, 8'h11, 0, 1, 0, 0, 0);
        tbl[24] = mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 8'h11, 0, 1, 0, 0, 0);
        tbl[25] = mk(1, 4'h0, 4'h0, 0, 1, 0, 1, 4'h0, 0, 8'h11, 0, 0, 0, 0, 1);
        for (int i = 0; i < 26; i++) begin
            rst_n = tbl[i].rst_n; req_valid = tbl[i].v; req_last = tbl[i].l;
            uart_busy = tbl[i].b; uart_done = tbl[i].d; uart_error = tbl[i].e;
            step();
            chk($sformatf("r%0d_enable", i), uart_enable, tbl[i].en);
            chk($sformatf("r%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("r%0d_write", i), uart_write, tbl[i].w);
            chk($sformatf("r%0d_data", i), uart_data, tbl[i].dat);
            chk($sformatf("r%0d_grant", i), grant_id, tbl[i].g);
            chk($sformatf("r%0d_arb_busy", i), arb_busy, tbl[i].ab);
            chk($sformatf("r%0d_err_timeout", i), err_timeout, tbl[i].et);
            chk($sformatf("r%0d_err_uart", i), err_uart, tbl[i].eu);
            chk($sformatf("r%0d_bytes", i), bytes_sent, tbl[i].by);
        end
        uart_busy = 0; uart_done = 0; uart_error = 0;
        busy_m = 0; pend_w = 0; k_m = 0;
        for (int i = 0; i < NR; i++) begin hd[i] = 0; len[i] = 0; end
        model_on = 1;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        p_m = 0;
        exp_bytes = 16'h0;
        for (int r = 0; r < 6; r++) begin
            gen_round();
            run_round();
        end
        force dut.bytes_sent = 16'hFFFF;
        #1;
        release dut.bytes_sent;
        exp_bytes = 16'hFFFF;
        for (int i = 0; i < NR; i++) begin hd[i] = 0; len[i] = 0; end
        bd[1][0] = 8'hA5; bl[1][0] = 1'b1; len[1] = 1;
        run_round();
        chk("wrap_bytes_zero", bytes_sent, 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ byte-stream requesters, such as the telemetry, command-echo and debug sources.
- Arbitration is round-robin.
- A message (bytes up to and including one flagged last) is never interleaved with another requester's bytes.
- The block sequences the transmitter's enable/write/data handshake and watches done/busy/error.
- It runs in the baud clock domain, beside uart_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_BITS, `NUM_DATA_BITS (8), byte width; must match uart_tx
- ACCEPT_TIMEOUT, 4, baud cycles allowed between write and uart_busy rising

Ports:
- baud  in  1  clock; one clock only
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  requester i has a byte on its data slice
- req_last  in  NUM_REQ  byte is the final byte of requester i's message
- req_data  in  NUM_REQ*DATA_BITS  slice i = bits [i*DATA_BITS +: DATA_BITS]
- req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i consumed
- grant_id  out  $clog2(NUM_REQ)  current/last owner
- arb_busy  out  1  a message is in progress (lock held or byte in flight)
- bytes_sent  out  16  count of bytes completed (done seen); wraps 0xFFFF->0
- err_timeout  out  1  sticky; uart_tx failed to accept a write
- err_uart  out  1  sticky OR of uart_error
- uart_enable  out  1  to uart_tx enable
- uart_write  out  1  to uart_tx write
- uart_data  out  DATA_BITS  to uart_tx data
- uart_done  in  1  from uart_tx done
- uart_busy  in  1  from uart_tx busy
- uart_error  in  1  from uart_tx error

Behaviour:
- Reset (rst_n=0 at edge):
  - state=ST_IDLE; all outputs 0, including uart_enable (this forces uart_tx to its own reset).
  - rr pointer=0; lock=0; timeout counter=0.
  - Reset mid-byte abandons the byte; no req_ready is re-issued.
- First edge with rst_n=1: uart_enable<=1, held high thereafter.
- ST_IDLE:
  - If lock=1: serve only grant_id; wait indefinitely for its req_valid.
  - Else: choose the first asserted req_valid searching from rr pointer upward, modulo NUM_REQ.
  - On a winner w, in the same edge: uart_data<=slice w; uart_write<=1; req_ready[w]<=1 (single cycle); grant_id<=w; lock<=~req_last[w]; last_flag<=req_last[w]; arb_busy<=1; state->ST_ACCEPT.
- Issue is also gated: if uart_busy=1 or uart_enable=0, no issue occurs.
- ST_ACCEPT:
  - uart_write<=0 and req_ready<=0 at the first edge (write is exactly one cycle).
  - Count cycles; on uart_busy=1 -> ST_WAIT_DONE.
  - If the count reaches ACCEPT_TIMEOUT with no busy: err_timeout<=1; lock<=0; rr<=grant_id+1; arb_busy<=0; -> ST_IDLE.
- ST_WAIT_DONE:
  - On uart_done=1: bytes_sent++; -> ST_IDLE.
  - If last_flag: lock<=0; rr<=grant_id+1 (wrap); arb_busy<=0.
  - done coincides with uart_tx's IDLE cycle, so the next issue from ST_IDLE on the following edge gives a 1-baud gap between stop bit and next start bit.
- Latency: req_valid sampled at edge E0 -> write high after E0 -> uart_tx start bit after E1 -> busy seen at E2.
- Byte period from issue to return to ST_IDLE = DATA_BITS+4 baud cycles.
- uart_data is held stable from issue until the next issue.
- req_data must be held only until req_ready; valid may drop anytime before grant.
- Simultaneous valids: rr order decides. A requester dropping req_valid mid-message stalls the lock; it is not preempted.
- uart_error, uart_done: uart_error sets err_uart in any state; uart_done outside ST_WAIT_DONE is ignored.
- err flags clear only on reset.

Decomposition:
- Add to uart_globals package:
  - arbiter state encodings ST_IDLE/ST_ACCEPT/ST_WAIT_DONE
  - byte period constant (NUM_DATA_BITS+4)
- One sub-module: rr_picker (combinational-plus-pointer round-robin select over NUM_REQ; outputs winner index and found flag). It is reusable by the planned rx dispatch block.

Test Plan:
- Single byte: req_valid[1]=1, data 0xA5, last=1, uart_tx instantiated -> req_ready[1] pulses once, tx line shows 0,1,0,1,0,0,1,0,1,parity,1, bytes_sent=1, arb_busy falls.
- Contention: req 0 and 2 valid, last=1, data 0x11/0x22 -> order 0x11 then 0x22; second start bit exactly 1 baud after first stop bit; then req 0 again wins after 2.
- Message lock: req 3 sends 0x01,0x02,0x03 (last on 0x03) while req 0 is held valid -> all three req 3 bytes go before any req 0 byte; grant_id=3 throughout.
- Timeout: stub uart_busy=0 permanently, req 1 valid -> write high exactly 1 cycle, err_timeout=1 after 4 cycles, lock released, req 2 subsequently granted.
- Reset mid-byte: drop rst_n during ST_WAIT_DONE at data bit 3 -> next edge all outputs 0, uart_enable=0, tx returns high; after release a fresh byte transmits correctly with bytes_sent=0→1.
- Wrap: preload bytes_sent to 0xFFFF via 65535 bytes (or a force) -> next done gives 0x0000.
